id_operand_stage: RTL and testbench
===================================

Name: id_operand_stage

Overview:
- Decode-stage operand fetch unit; sits directly upstream of the two-read/one-write register file and drives its read ports.
- Selects operands from regfile data, EX/MEM forwarding or immediate; detects load-use hazards and generates a stall.
- Registers the result into the ID/EX pipeline register with valid/stall/flush handling and a saturating stall counter.

Parameters:
DATA_W, 32, operand/data width
ADDR_W, 5, register address width (register 0 hardwired zero)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  decoded instruction present
in_ready  out  1  instruction accepted this cycle
rs_addr  in  ADDR_W  source 1 address
rt_addr  in  ADDR_W  source 2 address
use_rs  in  1  op1 needs rs
use_rt  in  1  op2 needs rt (else immediate)
imm  in  DATA_W  extended immediate
dst_addr  in  ADDR_W  destination register
dst_we  in  1  instruction writes a register
is_load  in  1  instruction is a load
re1, re2  out  1  regfile read enables
raddr1, raddr2  out  ADDR_W  regfile read addresses
rdata1, rdata2  in  DATA_W  regfile read data (WB bypass already applied)
fw_ex_we, fw_ex_is_load  in  1  EX-stage result write / is load
fw_ex_waddr  in  ADDR_W  EX-stage destination
fw_ex_wdata  in  DATA_W  EX-stage result
fw_mem_we  in  1  MEM-stage write
fw_mem_waddr  in  ADDR_W  MEM-stage destination
fw_mem_wdata  in  DATA_W  MEM-stage result (load data included)
stall_in  in  1  downstream stall, hold ID/EX
flush  in  1  kill ID/EX contents
stall_req  out  1  load-use stall to IF/ID
ex_valid, ex_we, ex_is_load  out  1  ID/EX registered controls
ex_op1, ex_op2  out  DATA_W  ID/EX registered operands
ex_waddr  out  ADDR_W  ID/EX registered destination
stall_cnt  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (async, rst=1): ex_valid, ex_we, ex_is_load, ex_op1, ex_op2, ex_waddr, stall_cnt all 0. Combinational outputs are gated: re1=re2=0, stall_req=0, in_ready=0.
- Read ports (combinational): re1=in_valid&use_rs, raddr1=rs_addr; re2=in_valid&use_rt, raddr2=rt_addr. Addresses are driven even when the enable is low.
- Operand select per source, first match wins:
  - address 0 -> 0;
  - fw_ex_we & fw_ex_waddr==addr -> fw_ex_wdata;
  - fw_mem_we & fw_mem_waddr==addr -> fw_mem_wdata;
  - else rdata.
- op1 = use_rs ? selected rs value : 0. op2 = use_rt ? selected rt value : imm.
- Load-use hazard: stall_req = in_valid & fw_ex_is_load & fw_ex_we & fw_ex_waddr!=0 & ((use_rs & rs_addr==fw_ex_waddr) | (use_rt & rt_addr==fw_ex_waddr)).
- in_ready = in_valid & !stall_req & !stall_in.
- ID/EX update at each posedge, in priority order:
  - flush=1: ex_valid=0, ex_we=0, ex_is_load=0. flush beats stall_in and stall_req.
  - stall_in=1: all ID/EX registers hold.
  - stall_req=1: insert bubble (ex_valid=0, ex_we=0, ex_is_load=0; operands don't-care, hold).
  - in_valid=1: load ex_op1, ex_op2, ex_waddr=dst_addr, ex_we=dst_we&dst_addr!=0, ex_is_load, ex_valid=1.
  - else: ex_valid=0, ex_we=0.
- stall_cnt increments by 1 each cycle in which stall_req=1 and stall_in=0 and flush=0; saturates at all-ones.
- Latency: one cycle from in_ready to ex_valid.
- A load-use stall lasts exactly one cycle; the next cycle the load is in MEM and fw_mem forwarding resolves the operand.
- Reset asserted mid-operation clears immediately regardless of stall/flush.

Test Plan:
- Reset: rst=1 mid-run with ex_valid=1 -> all ex_* and stall_cnt read 0 asynchronously; in_ready=0.
- Plain read: rs=3, rt=4, use both, rdata1=0x11, rdata2=0x22, no forwards -> next cycle ex_op1=0x11, ex_op2=0x22, ex_valid=1.
- Forward priority: rs=5, fw_ex(5,0xAAAA), fw_mem(5,0xBBBB) -> ex_op1=0xAAAA. Repeat with fw_ex_we=0 -> 0xBBBB. Repeat with rs=0 -> 0.
- Load-use: fw_ex_is_load=1, fw_ex_waddr=7, rt=7 -> stall_req=1, in_ready=0, ex_valid=0 next cycle, stall_cnt=1. Following cycle fw_mem(7,0x1234) -> ex_op2=0x1234.
- Immediate/dest0: use_rt=0, imm=0xFFFF8000, dst_addr=0, dst_we=1 -> ex_op2=0xFFFF8000, ex_we=0.
- Stall vs flush: stall_in=1 holds ex_op1 for 3 cycles. Then flush=1 together with stall_in=1 -> ex_valid=0 next cycle.
- Counter saturation: CNT_W=2 with 5 consecutive load-use stalls -> stall_cnt=3.

Source files
------------

// File: rtl/id_operand_if.sv
// Bundle of the decode-stage operand fetch signals: the incoming decoded
// instruction, the register-file read ports, the EX/MEM forwarding paths,
// the pipeline control inputs and the registered ID/EX outputs.
// slave  = the operand stage itself, master = its surroundings.
interface id_operand_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              use_rs;
  logic              use_rt;
  logic [DATA_W-1:0] imm;
  logic [ADDR_W-1:0] dst_addr;
  logic              dst_we;
  logic              is_load;
  logic              re1;
  logic              re2;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              fw_ex_we;
  logic              fw_ex_is_load;
  logic [ADDR_W-1:0] fw_ex_waddr;
  logic [DATA_W-1:0] fw_ex_wdata;
  logic              fw_mem_we;
  logic [ADDR_W-1:0] fw_mem_waddr;
  logic [DATA_W-1:0] fw_mem_wdata;
  logic              stall_in;
  logic              flush;
  logic              stall_req;
  logic              ex_valid;
  logic              ex_we;
  logic              ex_is_load;
  logic [DATA_W-1:0] ex_op1;
  logic [DATA_W-1:0] ex_op2;
  logic [ADDR_W-1:0] ex_waddr;
  logic [CNT_W-1:0]  stall_cnt;

  modport slave (
    input  in_valid, rs_addr, rt_addr, use_rs, use_rt, imm, dst_addr, dst_we, is_load,
    input  rdata1, rdata2,
    input  fw_ex_we, fw_ex_is_load, fw_ex_waddr, fw_ex_wdata,
    input  fw_mem_we, fw_mem_waddr, fw_mem_wdata,
    input  stall_in, flush,
    output in_ready, re1, re2, raddr1, raddr2, stall_req,
    output ex_valid, ex_we, ex_is_load, ex_op1, ex_op2, ex_waddr, stall_cnt
  );

  modport master (
    output in_valid, rs_addr, rt_addr, use_rs, use_rt, imm, dst_addr, dst_we, is_load,
    output rdata1, rdata2,
    output fw_ex_we, fw_ex_is_load, fw_ex_waddr, fw_ex_wdata,
    output fw_mem_we, fw_mem_waddr, fw_mem_wdata,
    output stall_in, flush,
    input  in_ready, re1, re2, raddr1, raddr2, stall_req,
    input  ex_valid, ex_we, ex_is_load, ex_op1, ex_op2, ex_waddr, stall_cnt
  );
endinterface

// File: rtl/id_operand_stage.sv
// Decode-stage operand fetch: drives the register-file read ports, picks each
// operand from zero / EX forward / MEM forward / regfile / immediate, raises a
// one-cycle load-use stall, and registers the result into ID/EX.
module id_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  id_operand_if.slave bus
);

  // Register 0 reads as zero; the youngest producer (EX) wins over MEM,
  // and the regfile data already carries the WB bypass.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] rdata,
    input logic              ex_we,
    input logic [ADDR_W-1:0] ex_waddr,
    input logic [DATA_W-1:0] ex_wdata,
    input logic              mem_we,
    input logic [ADDR_W-1:0] mem_waddr,
    input logic [DATA_W-1:0] mem_wdata
  );
    logic [DATA_W-1:0] val;
    if (addr == {ADDR_W{1'b0}}) begin
      val = {DATA_W{1'b0}};
    end else if (ex_we && (ex_waddr == addr)) begin
      val = ex_wdata;
    end else if (mem_we && (mem_waddr == addr)) begin
      val = mem_wdata;
    end else begin
      val = rdata;
    end
    return val;
  endfunction

  logic [DATA_W-1:0] op1_s;
  logic [DATA_W-1:0] op2_s;
  logic              hazard_s;

  logic              ex_valid_r;
  logic              ex_we_r;
  logic              ex_is_load_r;
  logic [DATA_W-1:0] ex_op1_r;
  logic [DATA_W-1:0] ex_op2_r;
  logic [ADDR_W-1:0] ex_waddr_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  // Operand selection and load-use hazard detection.
  always_comb begin
    op1_s    = {DATA_W{1'b0}};
    op2_s    = bus.imm;
    hazard_s = 1'b0;
    if (bus.use_rs) begin
      op1_s = pick_operand(bus.rs_addr, bus.rdata1, bus.fw_ex_we, bus.fw_ex_waddr,
                           bus.fw_ex_wdata, bus.fw_mem_we, bus.fw_mem_waddr, bus.fw_mem_wdata);
    end else begin
      op1_s = {DATA_W{1'b0}};
    end
    if (bus.use_rt) begin
      op2_s = pick_operand(bus.rt_addr, bus.rdata2, bus.fw_ex_we, bus.fw_ex_waddr,
                           bus.fw_ex_wdata, bus.fw_mem_we, bus.fw_mem_waddr, bus.fw_mem_wdata);
    end else begin
      op2_s = bus.imm;
    end
    // A load in EX has no data yet, so a dependent instruction waits one cycle
    // until the value appears on the MEM forwarding path.
    hazard_s = bus.in_valid & bus.fw_ex_is_load & bus.fw_ex_we &
               (bus.fw_ex_waddr != {ADDR_W{1'b0}}) &
               ((bus.use_rs & (bus.rs_addr == bus.fw_ex_waddr)) |
                (bus.use_rt & (bus.rt_addr == bus.fw_ex_waddr)));
  end

  // Handshake and read-port outputs, forced quiet while reset is held.
  assign bus.re1       = ~rst & bus.in_valid & bus.use_rs;
  assign bus.re2       = ~rst & bus.in_valid & bus.use_rt;
  assign bus.raddr1    = bus.rs_addr;
  assign bus.raddr2    = bus.rt_addr;
  assign bus.stall_req = ~rst & hazard_s;
  assign bus.in_ready  = ~rst & bus.in_valid & ~hazard_s & ~bus.stall_in;

  // ID/EX pipeline register: flush > downstream stall > load-use bubble > load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_r   <= 1'b0;
      ex_we_r      <= 1'b0;
      ex_is_load_r <= 1'b0;
      ex_op1_r     <= {DATA_W{1'b0}};
      ex_op2_r     <= {DATA_W{1'b0}};
      ex_waddr_r   <= {ADDR_W{1'b0}};
    end else if (bus.flush) begin
      ex_valid_r   <= 1'b0;
      ex_we_r      <= 1'b0;
      ex_is_load_r <= 1'b0;
    end else if (bus.stall_in) begin
      ex_valid_r   <= ex_valid_r;
      ex_we_r      <= ex_we_r;
      ex_is_load_r <= ex_is_load_r;
    end else if (hazard_s) begin
      ex_valid_r   <= 1'b0;
      ex_we_r      <= 1'b0;
      ex_is_load_r <= 1'b0;
    end else if (bus.in_valid) begin
      ex_valid_r   <= 1'b1;
      ex_we_r      <= bus.dst_we & (bus.dst_addr != {ADDR_W{1'b0}});
      ex_is_load_r <= bus.is_load;
      ex_op1_r     <= op1_s;
      ex_op2_r     <= op2_s;
      ex_waddr_r   <= bus.dst_addr;
    end else begin
      ex_valid_r   <= 1'b0;
      ex_we_r      <= 1'b0;
    end
  end

  // Saturating count of load-use stall cycles actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (hazard_s && !bus.stall_in && !bus.flush &&
                 (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.ex_valid   = ex_valid_r;
  assign bus.ex_we      = ex_we_r;
  assign bus.ex_is_load = ex_is_load_r;
  assign bus.ex_op1     = ex_op1_r;
  assign bus.ex_op2     = ex_op2_r;
  assign bus.ex_waddr   = ex_waddr_r;
  assign bus.stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: a full-size instance for the datapath
// and a CNT_W=2 instance for counter saturation.
module tb_id_operand_stage;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  id_operand_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus ();
  id_operand_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(2))  sbus ();

  id_operand_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  id_operand_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid = 1'b0; bus.rs_addr = 5'd0; bus.rt_addr = 5'd0;
    bus.use_rs = 1'b0; bus.use_rt = 1'b0; bus.imm = 32'd0;
    bus.dst_addr = 5'd0; bus.dst_we = 1'b0; bus.is_load = 1'b0;
    bus.rdata1 = 32'd0; bus.rdata2 = 32'd0;
    bus.fw_ex_we = 1'b0; bus.fw_ex_is_load = 1'b0; bus.fw_ex_waddr = 5'd0; bus.fw_ex_wdata = 32'd0;
    bus.fw_mem_we = 1'b0; bus.fw_mem_waddr = 5'd0; bus.fw_mem_wdata = 32'd0;
    bus.stall_in = 1'b0; bus.flush = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk = 1'b0;
    rst = 1'b1;
    clear_inputs();
    sbus.in_valid = 1'b0; sbus.rs_addr = 5'd0; sbus.rt_addr = 5'd0;
    sbus.use_rs = 1'b0; sbus.use_rt = 1'b0; sbus.imm = 32'd0;
    sbus.dst_addr = 5'd0; sbus.dst_we = 1'b0; sbus.is_load = 1'b0;
    sbus.rdata1 = 32'd0; sbus.rdata2 = 32'd0;
    sbus.fw_ex_we = 1'b0; sbus.fw_ex_is_load = 1'b0; sbus.fw_ex_waddr = 5'd0; sbus.fw_ex_wdata = 32'd0;
    sbus.fw_mem_we = 1'b0; sbus.fw_mem_waddr = 5'd0; sbus.fw_mem_wdata = 32'd0;
    sbus.stall_in = 1'b0; sbus.flush = 1'b0;

    // Reset gating of combinational outputs with a valid instruction present.
    bus.in_valid = 1'b1; bus.use_rs = 1'b1; bus.use_rt = 1'b1;
    bus.rs_addr = 5'd3; bus.rt_addr = 5'd4;
    bus.rdata1 = 32'h11; bus.rdata2 = 32'h22;
    bus.dst_addr = 5'd9; bus.dst_we = 1'b1;
    #2;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_re1", bus.re1, 1'b0);
    chk("rst_ex_valid", bus.ex_valid, 1'b0);
    chk("rst_stall_cnt", bus.stall_cnt, 16'd0);
    rst = 1'b0;

    // Plain regfile read.
    #1;
    chk("rd_re1", bus.re1, 1'b1);
    chk("rd_re2", bus.re2, 1'b1);
    chk("rd_raddr1", bus.raddr1, 5'd3);
    chk("rd_raddr2", bus.raddr2, 5'd4);
    chk("rd_in_ready", bus.in_ready, 1'b1);
    step();
    chk("rd_ex_op1", bus.ex_op1, 32'h11);
    chk("rd_ex_op2", bus.ex_op2, 32'h22);
    chk("rd_ex_valid", bus.ex_valid, 1'b1);
    chk("rd_ex_we", bus.ex_we, 1'b1);
    chk("rd_ex_waddr", bus.ex_waddr, 5'd9);

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst = 1'b1;
    #1;
    chk("amid_ex_valid", bus.ex_valid, 1'b0);
    chk("amid_ex_we", bus.ex_we, 1'b0);
    chk("amid_ex_op1", bus.ex_op1, 32'd0);
    chk("amid_ex_op2", bus.ex_op2, 32'd0);
    chk("amid_ex_waddr", bus.ex_waddr, 5'd0);
    chk("amid_in_ready", bus.in_ready, 1'b0);
    rst = 1'b0;

    // Forwarding priority: EX over MEM over regfile, register 0 over all.
    clear_inputs();
    bus.in_valid = 1'b1; bus.use_rs = 1'b1; bus.rs_addr = 5'd5; bus.rdata1 = 32'h5555;
    bus.fw_ex_we = 1'b1; bus.fw_ex_waddr = 5'd5; bus.fw_ex_wdata = 32'hAAAA;
    bus.fw_mem_we = 1'b1; bus.fw_mem_waddr = 5'd5; bus.fw_mem_wdata = 32'hBBBB;
    step();
    chk("fw_ex_op1", bus.ex_op1, 32'hAAAA);
    chk("fw_ex_op2_zero_imm", bus.ex_op2, 32'd0);
    bus.fw_ex_we = 1'b0;
    step();
    chk("fw_mem_op1", bus.ex_op1, 32'hBBBB);
    bus.rs_addr = 5'd0; bus.fw_ex_we = 1'b1; bus.fw_ex_waddr = 5'd0; bus.fw_mem_waddr = 5'd0;
    step();
    chk("fw_r0_op1", bus.ex_op1, 32'd0);

    // Load-use hazard on rt, then resolution through MEM forwarding.
    clear_inputs();
    bus.in_valid = 1'b1; bus.use_rt = 1'b1; bus.rt_addr = 5'd7; bus.rdata2 = 32'hDEAD;
    bus.rs_addr = 5'd7; bus.dst_addr = 5'd8; bus.dst_we = 1'b1;
    bus.fw_ex_we = 1'b1; bus.fw_ex_is_load = 1'b1; bus.fw_ex_waddr = 5'd7;
    #1;
    chk("lu_stall_req", bus.stall_req, 1'b1);
    chk("lu_in_ready", bus.in_ready, 1'b0);
    step();
    chk("lu_bubble_valid", bus.ex_valid, 1'b0);
    chk("lu_stall_cnt", bus.stall_cnt, 16'd1);
    bus.fw_ex_we = 1'b0; bus.fw_ex_is_load = 1'b0;
    bus.fw_mem_we = 1'b1; bus.fw_mem_waddr = 5'd7; bus.fw_mem_wdata = 32'h1234;
    #1;
    chk("lu_resolved_req", bus.stall_req, 1'b0);
    step();
    chk("lu_ex_op2", bus.ex_op2, 32'h1234);
    chk("lu_ex_valid", bus.ex_valid, 1'b1);
    chk("lu_cnt_held", bus.stall_cnt, 16'd1);

    // No hazard when the matching source is unused or the load targets r0.
    clear_inputs();
    bus.in_valid = 1'b1; bus.rs_addr = 5'd7; bus.rt_addr = 5'd2; bus.use_rt = 1'b1;
    bus.fw_ex_we = 1'b1; bus.fw_ex_is_load = 1'b1; bus.fw_ex_waddr = 5'd7;
    #1;
    chk("nohaz_unused_rs", bus.stall_req, 1'b0);
    bus.rt_addr = 5'd0; bus.fw_ex_waddr = 5'd0;
    #1;
    chk("nohaz_r0", bus.stall_req, 1'b0);

    // Immediate operand and write to register 0.
    clear_inputs();
    bus.in_valid = 1'b1; bus.imm = 32'hFFFF8000; bus.dst_addr = 5'd0; bus.dst_we = 1'b1;
    bus.is_load = 1'b1;
    step();
    chk("imm_ex_op2", bus.ex_op2, 32'hFFFF8000);
    chk("imm_ex_op1", bus.ex_op1, 32'd0);
    chk("imm_ex_we", bus.ex_we, 1'b0);
    chk("imm_ex_is_load", bus.ex_is_load, 1'b1);
    bus.in_valid = 1'b0;
    step();
    chk("idle_ex_valid", bus.ex_valid, 1'b0);

    // Downstream stall holds ID/EX; flush overrides it.
    clear_inputs();
    bus.in_valid = 1'b1; bus.use_rs = 1'b1; bus.rs_addr = 5'd2; bus.rdata1 = 32'h77;
    bus.dst_addr = 5'd3; bus.dst_we = 1'b1;
    step();
    chk("hold_load_op1", bus.ex_op1, 32'h77);
    bus.stall_in = 1'b1; bus.rdata1 = 32'h99;
    #1;
    chk("hold_in_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_ex_op1", bus.ex_op1, 32'h77);
      chk("hold_ex_valid", bus.ex_valid, 1'b1);
    end
    bus.flush = 1'b1;
    step();
    chk("flush_ex_valid", bus.ex_valid, 1'b0);
    chk("flush_ex_we", bus.ex_we, 1'b0);

    // Flush or downstream stall suppress the stall counter.
    bus.stall_in = 1'b0; bus.use_rs = 1'b0; bus.use_rt = 1'b1; bus.rt_addr = 5'd7;
    bus.fw_ex_we = 1'b1; bus.fw_ex_is_load = 1'b1; bus.fw_ex_waddr = 5'd7;
    step();
    chk("flush_haz_cnt", bus.stall_cnt, 16'd1);
    chk("flush_haz_valid", bus.ex_valid, 1'b0);
    bus.flush = 1'b0; bus.stall_in = 1'b1;
    step();
    chk("stallin_haz_cnt", bus.stall_cnt, 16'd1);
    bus.stall_in = 1'b0;
    step();
    chk("haz_cnt_two", bus.stall_cnt, 16'd2);
    clear_inputs();

    // Saturation of a 2-bit counter over five consecutive load-use stalls.
    sbus.in_valid = 1'b1; sbus.use_rt = 1'b1; sbus.rt_addr = 5'd7;
    sbus.fw_ex_we = 1'b1; sbus.fw_ex_is_load = 1'b1; sbus.fw_ex_waddr = 5'd7;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("sat_stall_cnt", sbus.stall_cnt, (i < 3) ? 2'(i) : 2'd3);
    end
    chk("sat_ex_valid", sbus.ex_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
